// File: rtl/cpu_pkg.sv
// Shared CPU constants: front-end buffer depth and
// instruction field positions.
package cpu_pkg;

   localparam logic [1:0] IF_ID_DEPTH = 2'd2;

   localparam int OPC_MSB = 31;
   localparam int RD_MSB  = 23;
   localparam int RS1_MSB = 15;
   localparam int IMM_MSB = 7;
   localparam int FLD_W   = 8;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry first-word-fall-through buffer between fetch and
// decode, with flush and inline instruction field extraction.
module if_id_buffer
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [FLD_W-1:0]      out_opcode,
   output logic [FLD_W-1:0]      out_rd,
   output logic [FLD_W-1:0]      out_rs1,
   output logic [FLD_W-1:0]      out_imm,
   output logic [1:0]            count
);

   logic [ADDR_WIDTH-1:0] pc_q    [2];
   logic [DATA_WIDTH-1:0] instr_q [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            cnt_q;
   logic                  push;
   logic                  pop;

   // Handshake flags come only from registered occupancy.
   assign in_ready  = (cnt_q != IF_ID_DEPTH);
   assign out_valid = (cnt_q != 2'd0);

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
   assign out_instr = out_valid ? instr_q[rd_ptr] : '0;

   assign out_opcode = out_instr[OPC_MSB -: FLD_W];
   assign out_rd     = out_instr[RD_MSB  -: FLD_W];
   assign out_rs1    = out_instr[RS1_MSB -: FLD_W];
   assign out_imm    = out_instr[IMM_MSB -: FLD_W];

   assign count = cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (flush) begin
         cnt_q  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]    <= in_pc;
            instr_q[wr_ptr] <= in_instr;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case (1'b1)
            push && !pop: cnt_q <= cnt_q + 2'd1;
            pop && !push: cnt_q <= cnt_q - 2'd1;
            default:      cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized and directed bench for if_id_buffer against a
// queue-based model of the buffer contents.
module tb_if_id_buffer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_pc;
   logic [31:0] in_instr;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_pc;
   logic [31:0] out_instr;
   logic [7:0]  out_opcode;
   logic [7:0]  out_rd;
   logic [7:0]  out_rs1;
   logic [7:0]  out_imm;
   logic [1:0]  count;

   if_id_buffer #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_instr   (in_instr),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_instr  (out_instr),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_rs1    (out_rs1),
      .out_imm    (out_imm),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] instr;
   } ent_t;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      logic [31:0] ei;
      logic [7:0]  ep;
      ei = (q.size() != 0) ? q[0].instr : 32'h0;
      ep = (q.size() != 0) ? q[0].pc : 8'h0;
      chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("m_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("m_count", {30'b0, count}, q.size());
      chk("m_pc", {24'b0, out_pc}, {24'b0, ep});
      chk("m_instr", out_instr, ei);
      chk("m_fields", {out_opcode, out_rd, out_rs1, out_imm}, ei);
   endtask

   // Called at a negedge: drive, model the edge, check at next negedge.
   task automatic step(input logic v, input logic [7:0] pc,
                       input logic [31:0] ins, input logic rdy,
                       input logic fl);
      bit pu, po;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         po = (q.size() != 0) && rdy;
         pu = v && (q.size() < 2);
         if (po) void'(q.pop_front());
         if (pu) q.push_back('{pc, ins});
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      bit seen20;
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_instr  = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all();
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      reset = 1'b1;

      step(1, 8'h05, 32'h0A0B0C0D, 0, 0);
      chk("t1_valid", {31'b0, out_valid}, 32'd1);
      chk("t1_pc", {24'b0, out_pc}, 32'h05);
      chk("t1_fld", {out_opcode, out_rd, out_rs1, out_imm},
          32'h0A0B0C0D);
      chk("t1_count", {30'b0, count}, 32'd1);
      step(0, 0, 0, 0, 1);

      step(1, 8'h01, 32'h11111111, 0, 0);
      step(1, 8'h02, 32'h22222222, 0, 0);
      chk("t2_count", {30'b0, count}, 32'd2);
      chk("t2_ready", {31'b0, in_ready}, 32'd0);
      step(1, 8'h03, 32'h33333333, 0, 0);
      chk("t2_pc", {24'b0, out_pc}, 32'h01);

      step(0, 0, 0, 1, 0);
      chk("t3_pc", {24'b0, out_pc}, 32'h02);
      chk("t3_count", {30'b0, count}, 32'd1);
      chk("t3_ready", {31'b0, in_ready}, 32'd1);
      step(0, 0, 0, 1, 0);
      chk("t3_valid", {31'b0, out_valid}, 32'd0);
      chk("t3_instr", out_instr, 32'h0);

      step(1, 8'h07, 32'h07070707, 0, 0);
      step(1, 8'h10, 32'h10101010, 1, 0);
      chk("t4_count", {30'b0, count}, 32'd1);
      chk("t4_pc", {24'b0, out_pc}, 32'h10);

      step(1, 8'h11, 32'h12121212, 0, 0);
      chk("t5_pre", {30'b0, count}, 32'd2);
      step(1, 8'h20, 32'h20202020, 0, 1);
      chk("t5_count", {30'b0, count}, 32'd0);
      chk("t5_valid", {31'b0, out_valid}, 32'd0);
      seen20 = (out_pc == 8'h20);
      step(0, 0, 0, 0, 0);
      seen20 = seen20 || (out_pc == 8'h20);
      chk("t5_no20", {31'b0, seen20}, 32'd0);

      step(1, 8'h31, 32'h31313131, 0, 0);
      step(1, 8'h32, 32'h32323232, 0, 0);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("t6_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_count", {30'b0, count}, 32'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      step(1, 8'h44, 32'h44444444, 0, 0);
      chk("t6_push", {24'b0, out_pc}, 32'h44);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 60),
              8'($urandom), $urandom,
              ($urandom_range(0, 99) < 50),
              ($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
